// File: rtl/sm_board_pkg.sv
// Board-level debounce defaults and the stability-counter type shared by sm_debounce users.
package sm_board_pkg;

   localparam int unsigned SM_WIDTH   = 8;
   localparam int unsigned SM_CNT_W   = 16;
   localparam int unsigned SM_STABLE  = 4;
   localparam int unsigned STAB_CNT_W = 4;

   typedef logic [STAB_CNT_W-1:0] stab_cnt_t;

   // Counter value on which the next tick accepts the new level.
   function automatic stab_cnt_t stab_last(input int unsigned stable);
      return stab_cnt_t'(stable - 1);
   endfunction

endpackage

// File: rtl/sm_sync2.sv
// Two-flop synchronizer, WIDTH bits wide; output is the input delayed two clocks.
// Both stages reset asynchronously to RST_VAL so the debouncer sees a known level.
module sm_sync2 #(
   parameter int unsigned      WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RST_VAL;
         sync_q <= RST_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/sm_debounce.sv
// Multi-channel switch debouncer: sync, shared sample prescaler, per-channel stability counters.
// Macro SM_DEBOUNCE_EDGE_EN adds registered one-cycle sw_rise/sw_fall pulses after each sw_out change.
module sm_debounce
   import sm_board_pkg::*;
#(
   parameter int unsigned      WIDTH   = SM_WIDTH,
   parameter int unsigned      CNT_W   = SM_CNT_W,
   parameter int unsigned      STABLE  = SM_STABLE,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] sw_in,
   output logic [WIDTH-1:0] sw_out,
   output logic             tick
`ifdef SM_DEBOUNCE_EDGE_EN
   ,
   output logic [WIDTH-1:0] sw_rise,
   output logic [WIDTH-1:0] sw_fall
`endif
);

   localparam stab_cnt_t CNT_LAST = stab_last(STABLE);

   logic [WIDTH-1:0]            sync;
   logic [CNT_W-1:0]            presc_q, presc_d;
   logic [WIDTH-1:0]            out_q, out_d;
   stab_cnt_t [WIDTH-1:0]       cnt_q, cnt_d;

   sm_sync2 #(
      .WIDTH   (WIDTH),
      .RST_VAL (RST_VAL)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (sw_in),
      .q_o   (sync)
   );

   assign tick = (presc_q == {CNT_W{1'b1}});

   always_comb begin
      presc_d = presc_q + CNT_W'(1);
      out_d   = out_q;
      cnt_d   = cnt_q;
      for (int i = 0; i < int'(WIDTH); i++) begin
         // Any cycle of agreement, ticked or not, throws away qualification progress.
         if (sync[i] == out_q[i]) begin
            cnt_d[i] = '0;
         end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
               out_d[i] = sync[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + stab_cnt_t'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q <= '0;
         out_q   <= RST_VAL;
         cnt_q   <= '0;
      end else begin
         presc_q <= presc_d;
         out_q   <= out_d;
         cnt_q   <= cnt_d;
      end
   end

   assign sw_out = out_q;

`ifdef SM_DEBOUNCE_EDGE_EN
   logic [WIDTH-1:0] out_dly_q;
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;

   // Pulses land one cycle after sw_out changes; a channel cannot rise and fall at once.
   always_comb begin
      rise_d =  out_q & ~out_dly_q;
      fall_d = ~out_q &  out_dly_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_dly_q <= RST_VAL;
         rise_q    <= '0;
         fall_q    <= '0;
      end else begin
         out_dly_q <= out_q;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
      end
   end

   assign sw_rise = rise_q;
   assign sw_fall = fall_q;
`endif

endmodule

// File: tb/tb_sm_debounce.sv
// Directed bench for sm_debounce (WIDTH=2, CNT_W=4, STABLE=3): per-cycle model compare plus fixed-edge literals.
module tb_sm_debounce;

   localparam int W   = 2;
   localparam int CW  = 4;
   localparam int ST  = 3;
   localparam int PER = 16;

   logic         clk   = 1'b0;
   logic         rst_n = 1'b0;
   logic [W-1:0] sw_in = 2'b11;
   logic [W-1:0] sw_out;
   logic [W-1:0] sw_rise;
   logic [W-1:0] sw_fall;
   logic         tick;

   always #5 clk = ~clk;

   sm_debounce #(
      .WIDTH   (W),
      .CNT_W   (CW),
      .STABLE  (ST),
      .RST_VAL (2'b00)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_in   (sw_in),
      .sw_out  (sw_out),
      .tick    (tick)
`ifdef SM_DEBOUNCE_EDGE_EN
      ,
      .sw_rise (sw_rise),
      .sw_fall (sw_fall)
`endif
   );

`ifndef SM_DEBOUNCE_EDGE_EN
   assign sw_rise = '0;
   assign sw_fall = '0;
`endif

   // Model: a level is accepted on a tick once STABLE ticks have fallen inside an
   // unbroken run of disagreement between the 2-clk-delayed input and the output.
   int           m_c;
   int           run_start [W];
   logic [W-1:0] m_out, m_prev, m_rise, m_fall, m_s1, m_s2, m_nxt;
   int           m_n;
   int           edges;
   int           phase = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_c    = 0;
         m_out  = 2'b00;
         m_prev = 2'b00;
         m_rise = 2'b00;
         m_fall = 2'b00;
         m_s1   = 2'b00;
         m_s2   = 2'b00;
         for (int i = 0; i < W; i++) run_start[i] = -1;
      end else begin
         m_nxt = m_out;
         for (int i = 0; i < W; i++) begin
            if (m_s2[i] == m_out[i]) begin
               run_start[i] = m_c;
            end else if ((m_c % PER) == PER - 1) begin
               m_n = (m_c + 1) / PER - (run_start[i] + 1) / PER;
               if (m_n >= ST) begin
                  m_nxt[i]     = m_s2[i];
                  run_start[i] = m_c;
               end
            end
         end
         m_rise = m_out & ~m_prev;
         m_fall = ~m_out & m_prev;
         m_prev = m_out;
         m_out  = m_nxt;
         m_s2   = m_s1;
         m_s1   = sw_in;
         m_c    = m_c + 1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edges <= 0;
      else        edges <= edges + 1;
   end

   int           n_chk = 0;
   int           n_err = 0;
   int           first_tick = -1;
   int           chg_edge  [W] = '{-1, -1};
   int           rise_edge [W] = '{-1, -1};
   int           fall_edge [W] = '{-1, -1};
   int           n_chg     [W] = '{0, 0};
   int           n_rise    [W] = '{0, 0};
   int           n_fall    [W] = '{0, 0};
   int           both_rise_edge = -1;
   logic [W-1:0] last_out = 2'b00;
   logic         m_tick;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s t=%0t edge=%0d: got %0h want %0h", nm, $time, edges, act, exp);
      end
   endtask

   always @(negedge clk) begin
      m_tick = rst_n && ((m_c % PER) == PER - 1);
      chk("sw_out_model", 32'(sw_out), 32'(m_out));
      chk("tick_model",   32'(tick),   32'(m_tick));
`ifdef SM_DEBOUNCE_EDGE_EN
      chk("sw_rise_model", 32'(sw_rise), 32'(m_rise));
      chk("sw_fall_model", 32'(sw_fall), 32'(m_fall));
      chk("rise_fall_excl", 32'(sw_rise & sw_fall), 32'd0);
`endif

      if (rst_n) begin
         if (tick && first_tick < 0) first_tick = edges;
         for (int i = 0; i < W; i++) begin
            if (sw_out[i] != last_out[i]) begin
               chg_edge[i] = edges;
               n_chg[i]++;
            end
            if (sw_rise[i]) begin
               rise_edge[i] = edges;
               n_rise[i]++;
            end
            if (sw_fall[i]) begin
               fall_edge[i] = edges;
               n_fall[i]++;
            end
         end
         if (sw_rise == 2'b11) both_rise_edge = edges;
      end
      last_out = sw_out;

      if (!rst_n) begin
         chk("reset_sw_out", 32'(sw_out), 32'd0);
         chk("reset_tick",   32'(tick),   32'd0);
         chk("reset_pulses", 32'({sw_rise, sw_fall}), 32'd0);
      end else if (phase == 1) begin
         case (edges)
            80: begin
               chk("first_tick_cycle", 32'(first_tick + 1), 32'd16);
               chk("ch0_accept_edge",  32'(chg_edge[0]),    32'd64);
               chk("ch0_out_after",    32'(sw_out),         32'b01);
               chk("ch1_untouched",    32'(n_chg[1]),       32'd0);
`ifdef SM_DEBOUNCE_EDGE_EN
               chk("ch0_rise_edge",    32'(rise_edge[0]),   32'd65);
               chk("ch0_rise_count",   32'(n_rise[0]),      32'd1);
`endif
            end
            200: begin
               chk("bounce_no_change", 32'(n_chg[0]), 32'd1);
               chk("bounce_out",       32'(sw_out),   32'b01);
`ifdef SM_DEBOUNCE_EDGE_EN
               chk("bounce_no_fall",   32'(n_fall[0]), 32'd0);
               chk("bounce_no_rise",   32'(n_rise[0]), 32'd1);
`endif
            end
            256: begin
               chk("ch0_fall_accept",  32'(chg_edge[0]), 32'd240);
               chk("ch0_fall_out",     32'(sw_out),      32'b00);
`ifdef SM_DEBOUNCE_EDGE_EN
               chk("ch0_fall_edge",    32'(fall_edge[0]), 32'd241);
               chk("ch0_fall_count",   32'(n_fall[0]),    32'd1);
               chk("ch0_no_new_rise",  32'(n_rise[0]),    32'd1);
`endif
            end
            316: begin
               chk("both_accept_ch0",  32'(chg_edge[0]), 32'd304);
               chk("both_accept_ch1",  32'(chg_edge[1]), 32'd304);
               chk("both_out",         32'(sw_out),      32'b11);
`ifdef SM_DEBOUNCE_EDGE_EN
               chk("both_rise_edge",   32'(both_rise_edge), 32'd305);
               chk("ch1_rise_count",   32'(n_rise[1]),      32'd1);
`endif
            end
            358: chk("pre_reset_hold", 32'(sw_out), 32'b11);
            default: ;
         endcase
      end else if (phase == 3) begin
         case (edges)
            2:  chk("post_reset_out", 32'(sw_out), 32'b00);
            47: chk("requal_not_yet", 32'(sw_out), 32'b00);
            60: begin
               chk("requal_accept",  32'(chg_edge[1]), 32'd48);
               chk("requal_out",     32'(sw_out),      32'b10);
`ifdef SM_DEBOUNCE_EDGE_EN
               chk("requal_rise",    32'(rise_edge[1]), 32'd49);
`endif
            end
            default: ;
         endcase
      end
   end

   task automatic goto_edge(input int n);
      while (edges < n) begin
         @(posedge clk);
         #2;
      end
   endtask

   initial begin
      repeat (5) @(posedge clk);
      #2;
      sw_in = 2'b00;
      rst_n = 1'b1;
      phase = 1;
      goto_edge(20);  sw_in = 2'b01;
      goto_edge(80);  sw_in = 2'b00;
      goto_edge(100); sw_in = 2'b01;
      goto_edge(120); sw_in = 2'b00;
      goto_edge(140); sw_in = 2'b01;
      goto_edge(160); sw_in = 2'b00;
      goto_edge(180); sw_in = 2'b01;
      goto_edge(200); sw_in = 2'b00;
      goto_edge(260); sw_in = 2'b11;
      goto_edge(320); sw_in = 2'b10;
      goto_edge(360);
      rst_n = 1'b0;
      phase = 2;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      phase = 3;
      goto_edge(70);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/sm_debounce.md
SM_DEBOUNCE -- requirements
Module: sm_debounce

Interface
REQ-001 SHALL have parameter WIDTH, default 8: number of independent switch/button channels.
REQ-002 SHALL have parameter CNT_W, default 16: prescaler width; sample tick period is 2^CNT_W clk cycles (1.31 ms at 50 MHz).
REQ-003 SHALL have parameter STABLE, default 4, legal range 1..15: consecutive differing ticks required to accept a new level.
REQ-004 SHALL have parameter RST_VAL, default all zeros, WIDTH bits: value of sw_out during reset.
REQ-005 clk  input  1  system clock, 50 MHz board clock; all state on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 sw_in  input  WIDTH  raw asynchronous switch levels from board pins.
REQ-008 sw_out  output  WIDTH  debounced, synchronized levels (registered).
REQ-009 sw_rise  output  WIDTH  one-clk pulse per channel when sw_out goes 0->1 (present only with SM_DEBOUNCE_EDGE_EN).
REQ-010 sw_fall  output  WIDTH  one-clk pulse per channel when sw_out goes 1->0 (present only with SM_DEBOUNCE_EDGE_EN).
REQ-011 tick  output  1  one-clk pulse marking each sample instant, for bench and for sharing with other blocks.

Function
REQ-012 Each sw_in bit SHALL pass through a two-flop synchronizer; sync value = sw_in delayed 2 clk.
REQ-013 Prescaler SHALL be a free-running CNT_W-bit up-counter wrapping from all-ones to zero; tick = 1 in the cycle the counter equals all-ones.
REQ-014 Each channel SHALL hold a 4-bit stability counter cnt.
REQ-015 In any cycle where sync == sw_out for a channel, that channel's cnt SHALL clear to 0, regardless of tick.
REQ-016 In a tick cycle where sync != sw_out: if cnt == STABLE-1, sw_out SHALL load sync and cnt SHALL clear; otherwise cnt SHALL increment by 1.
REQ-017 In a non-tick cycle where sync != sw_out, cnt SHALL hold.
REQ-018 A bounce (sync returning to sw_out) between ticks SHALL restart qualification from cnt = 0.
REQ-019 Latency: a clean level change SHALL appear on sw_out on the STABLE-th tick after sync changes, i.e. 2 clk + (STABLE-1)*2^CNT_W to STABLE*2^CNT_W clk after sw_in.
REQ-020 Channels SHALL be fully independent; simultaneous changes on several channels SHALL each be accepted on the same tick.
REQ-021 sw_rise[i]/sw_fall[i] SHALL be asserted exactly in the cycle after sw_out[i] updates (compare sw_out with its one-cycle-delayed copy), for one cycle.
REQ-022 sw_rise and sw_fall SHALL never both be 1 on one channel in the same cycle.

Reset
REQ-023 While rst_n = 0: synchronizer flops = RST_VAL, sw_out = RST_VAL, all cnt = 0, prescaler = 0, tick = 0, sw_rise = sw_fall = 0.
REQ-024 Reset asserted mid-qualification SHALL discard progress; after release qualification restarts from cnt = 0 and prescaler = 0.
REQ-025 First tick after reset release SHALL occur 2^CNT_W cycles after the first clk edge with rst_n = 1.

Configuration
REQ-026 Macro SM_DEBOUNCE_EDGE_EN: defined -> sw_rise, sw_fall ports and delayed-copy register exist per REQ-021; undefined -> those ports and registers are absent, sw_out and tick unchanged.

Structure
REQ-027 Default WIDTH, CNT_W, STABLE constants SHALL live in shared package sm_board_pkg for use by board top levels.
REQ-028 One sub-module sm_sync2 (two-flop synchronizer, WIDTH-wide, async active-low reset to parameter value) SHALL be instantiated; prescaler and per-channel counters stay in sm_debounce.

Verification (bench uses WIDTH=2, CNT_W=4, STABLE=3, RST_VAL=0, SM_DEBOUNCE_EDGE_EN defined)
REQ-029 Reset held 5 cycles with sw_in=2'b11 -> sw_out=0, tick=0, sw_rise=sw_fall=0 throughout; tick first at cycle 16 after release.
REQ-030 sw_in[0] 0->1 held steady -> sw_out[0]=1 on 3rd tick after sync change, sw_rise[0]=1 for exactly one cycle next cycle; sw_out[1] stays 0.
REQ-031 sw_in[0] toggles 1->0->1 every 20 cycles (crossing ticks) -> sw_out[0] never changes, no pulses.
REQ-032 Both bits 0->1 in same cycle -> both sw_out bits update on same tick, sw_rise=2'b11 for one cycle.
REQ-033 After sw_out[0]=1, sw_in[0]->0 for 3 ticks -> sw_out[0]=0, sw_fall[0] one-cycle pulse, sw_rise[0] stays 0.
REQ-034 rst_n pulsed low after 2 qualifying ticks -> sw_out stays RST_VAL; full 3 new ticks required after release.
